// File: rtl/qlal4s3b_cell_macro.sv
// Clock/reset macro: derives two programmable divided clocks from clk, each with
// a reset that is held for a set number of periods and then released on a falling edge.
module qlal4s3b_cell_macro #(
  parameter int CLK0_DIV   = 2,
  parameter int CLK1_DIV   = 4,
  parameter int RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic       Sys_Clk0,
  output logic       Sys_Clk0_Rst,
  output logic       Sys_Clk1,
  output logic       Sys_Clk1_Rst
);

  localparam int RC_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_DONE = RC_W'(RST_CYCLES);
  localparam logic [7:0] RST_DIV0 = (CLK0_DIV < 2) ? 8'd2 : 8'(CLK0_DIV);
  localparam logic [7:0] RST_DIV1 = (CLK1_DIV < 2) ? 8'd2 : 8'(CLK1_DIV);
  localparam logic [1:0][7:0] RST_DIV = {RST_DIV1, RST_DIV0};

  // Divisors below 2 cannot produce a clock, so they are promoted to 2.
  function automatic logic [7:0] clamp_div(input logic [7:0] v);
    return (v < 8'd2) ? 8'd2 : v;
  endfunction

  logic [1:0][7:0] div_reg;
  logic [1:0]      en_reg;
  logic [1:0]      ch_clk;
  logic [1:0]      ch_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= RST_DIV;
      en_reg  <= 2'b11;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    div_reg[0] <= clamp_div(cfg_wdata);
        2'd1:    div_reg[1] <= clamp_div(cfg_wdata);
        2'd2:    en_reg     <= cfg_wdata[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = div_reg[0];
      2'd1:    cfg_rdata = div_reg[1];
      2'd2:    cfg_rdata = {6'b0, en_reg};
      default: cfg_rdata = {6'b0, ch_rst};
    endcase
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [7:0]      cnt;
    logic [7:0]      div_act;
    logic            running;
    logic            clk_q;
    logic            rst_q;
    logic [RC_W-1:0] rst_cnt;

    logic [7:0] half;
    logic [7:0] cnt_d;
    logic [7:0] div_d;
    logic       run_d;
    logic       clk_d;

    // Next phase: divisor and enable are only re-sampled at a wrap or while stopped.
    always_comb begin
      half  = 8'((9'(div_act) + 9'd1) >> 1);
      cnt_d = cnt;
      div_d = div_act;
      run_d = running;
      clk_d = 1'b0;
      if (running) begin
        clk_d = (cnt < half);
        if (cnt == div_act - 8'd1) begin
          cnt_d = 8'd0;
          div_d = div_reg[ch];
          run_d = en_reg[ch];
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end else begin
        div_d = div_reg[ch];
        if (en_reg[ch]) begin
          clk_d = 1'b1;
          cnt_d = 8'd1;
          run_d = 1'b1;
        end
      end
    end

    // Reset release waits for RST_CYCLES rising edges, then drops with the next falling edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= 8'd0;
        div_act <= RST_DIV[ch];
        running <= 1'b0;
        clk_q   <= 1'b0;
        rst_q   <= 1'b1;
        rst_cnt <= '0;
      end else begin
        cnt     <= cnt_d;
        div_act <= div_d;
        running <= run_d;
        clk_q   <= clk_d;
        if (!clk_q && clk_d && (rst_cnt != RC_DONE))
          rst_cnt <= rst_cnt + 1'b1;
        if ((rst_cnt == RC_DONE) && clk_q && !clk_d)
          rst_q <= 1'b0;
      end
    end

    assign ch_clk[ch] = clk_q;
    assign ch_rst[ch] = rst_q;
  end

  assign Sys_Clk0     = ch_clk[0];
  assign Sys_Clk1     = ch_clk[1];
  assign Sys_Clk0_Rst = ch_rst[0];
  assign Sys_Clk1_Rst = ch_rst[1];

endmodule

// File: tb/tb_qlal4s3b_cell_macro.sv
// Scoreboard bench for qlal4s3b_cell_macro: a waveform-segment model predicts every
// cycle's outputs, a monitor compares them against the DUT.
module tb_qlal4s3b_cell_macro;
  localparam int CLK0_DIV   = 2;
  localparam int CLK1_DIV   = 4;
  localparam int RST_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic [7:0] cfg_rdata;
  logic       Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst;

  qlal4s3b_cell_macro #(
    .CLK0_DIV(CLK0_DIV), .CLK1_DIV(CLK1_DIV), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .Sys_Clk0(Sys_Clk0), .Sys_Clk0_Rst(Sys_Clk0_Rst),
    .Sys_Clk1(Sys_Clk1), .Sys_Clk1_Rst(Sys_Clk1_Rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       c0;
    logic       c1;
    logic       r0;
    logic       r1;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: each channel's future output is a queue of whole periods (H highs, D-H lows).
  bit wave0[$];
  bit wave1[$];
  int div_m[2];
  bit en_m[2];
  bit stop_m[2];
  bit prev_m[2];
  bit rst_m[2];
  int rises_m[2];

  function automatic void push_seg(int c, int d);
    for (int i = 0; i < d; i++) begin
      if (c == 0) wave0.push_back(i < (d + 1) / 2);
      else        wave1.push_back(i < (d + 1) / 2);
    end
  endfunction

  function automatic bit pop_wave(int c);
    if (c == 0) return wave0.pop_front();
    return wave1.pop_front();
  endfunction

  function automatic int wave_len(int c);
    return (c == 0) ? wave0.size() : wave1.size();
  endfunction

  function automatic exp_t model_edge(bit r, bit we, logic [1:0] a, logic [7:0] d);
    exp_t e;
    bit   ce[2];
    if (r) begin
      div_m[0] = (CLK0_DIV < 2) ? 2 : CLK0_DIV;
      div_m[1] = (CLK1_DIV < 2) ? 2 : CLK1_DIV;
      wave0.delete();
      wave1.delete();
      for (int c = 0; c < 2; c++) begin
        en_m[c] = 1'b1; stop_m[c] = 1'b1; prev_m[c] = 1'b0;
        rst_m[c] = 1'b1; rises_m[c] = 0; ce[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (stop_m[c]) begin
          if (en_m[c]) begin
            push_seg(c, div_m[c]);
            stop_m[c] = 1'b0;
            ce[c] = pop_wave(c);
          end else begin
            ce[c] = 1'b0;
          end
        end else begin
          ce[c] = pop_wave(c);
          if (wave_len(c) == 0) begin
            if (en_m[c]) push_seg(c, div_m[c]);
            else         stop_m[c] = 1'b1;
          end
        end
        if (!prev_m[c] && ce[c]) rises_m[c]++;
        else if (prev_m[c] && !ce[c] && rises_m[c] >= RST_CYCLES) rst_m[c] = 1'b0;
        prev_m[c] = ce[c];
      end
      if (we) begin
        case (a)
          2'd0: div_m[0] = (d < 2) ? 2 : int'(d);
          2'd1: div_m[1] = (d < 2) ? 2 : int'(d);
          2'd2: begin en_m[0] = d[0]; en_m[1] = d[1]; end
          default: ;
        endcase
      end
    end
    e.c0 = ce[0];
    e.c1 = ce[1];
    e.r0 = rst_m[0];
    e.r1 = rst_m[1];
    case (a)
      2'd0:    e.rd = 8'(div_m[0]);
      2'd1:    e.rd = 8'(div_m[1]);
      2'd2:    e.rd = {6'b0, en_m[1], en_m[0]};
      default: e.rd = {6'b0, rst_m[1], rst_m[0]};
    endcase
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit we, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    cfg_we = we;
    cfg_addr = a;
    cfg_wdata = d;
    sb.push_back(model_edge(r, we, a, d));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("Sys_Clk0", int'(Sys_Clk0), int'(e.c0));
        check("Sys_Clk1", int'(Sys_Clk1), int'(e.c1));
        check("Sys_Clk0_Rst", int'(Sys_Clk0_Rst), int'(e.r0));
        check("Sys_Clk1_Rst", int'(Sys_Clk1_Rst), int'(e.r1));
        check("cfg_rdata", int'(cfg_rdata), int'(e.rd));
      end
    end
  end

  initial begin : stimulus
    bit         r, we;
    logic [1:0] a;
    logic [7:0] d;

    repeat (3) cycle(1'b1, 1'b0, 2'd3, 8'd0);
    cycle(1'b1, 1'b1, 2'd0, 8'd9);
    idle(90);

    cycle(1'b0, 1'b1, 2'd0, 8'd5);
    idle(30);
    cycle(1'b0, 1'b1, 2'd1, 8'd0);
    idle(30);
    cycle(1'b0, 1'b1, 2'd2, 8'h02);
    idle(20);
    cycle(1'b0, 1'b1, 2'd2, 8'h03);
    idle(20);
    cycle(1'b0, 1'b1, 2'd3, 8'hFF);
    idle(5);

    cycle(1'b1, 1'b0, 2'd3, 8'd0);
    idle(100);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      we = ($urandom_range(0, 5) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a < 2'd2)
        d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      else
        d = 8'($urandom_range(0, 255));
      cycle(r, we, a, d);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
